// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the whack-a-mole hit arbiter.
package hit_judge_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, HIT, DONE} state_t;

    localparam logic [3:0] KEY_NONE      = 4'hF;
    localparam logic [6:0] HIT_COUNT_MAX = 7'd99;

    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v >= HIT_COUNT_MAX) ? HIT_COUNT_MAX : v + 7'd1;
    endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Keypad/mole inputs and score/VGA outputs of the hit arbiter.
interface hit_judge_if;

    logic       scan_clk;
    logic       inGame;
    logic       stop;
    logic [3:0] position;
    logic [3:0] keypadCol;
    logic [3:0] keypadBuf;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       escape_pulse;
    logic       hit_level;
    logic [6:0] hit_count;

    modport slave (
        input  scan_clk, inGame, stop, position, keypadCol, keypadBuf,
        output hit_pulse, miss_pulse, escape_pulse, hit_level, hit_count
    );

    modport master (
        output scan_clk, inGame, stop, position, keypadCol, keypadBuf,
        input  hit_pulse, miss_pulse, escape_pulse, hit_level, hit_count
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes scan tick and keypad columns, turns a held key into one press strobe.
module key_debounce
    import hit_judge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_scan_clk,
    input  logic [3:0] i_col,
    output logic       o_tick,
    output logic       o_press
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          r_scan_s1, r_scan_s2, r_scan_d;
    logic [3:0]    r_col_s1, r_col_s2;
    logic [CW-1:0] r_cnt;
    logic          w_down;

    assign w_down  = (r_col_s2 != KEY_NONE);
    assign o_tick  = r_scan_s2 & ~r_scan_d;
    // Fires only on the step into saturation, so a held key never repeats.
    assign o_press = o_tick & w_down & (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_s1 <= 1'b0;
            r_scan_s2 <= 1'b0;
            r_scan_d  <= 1'b0;
            r_col_s1  <= KEY_NONE;
            r_col_s2  <= KEY_NONE;
            r_cnt     <= '0;
        end else begin
            r_scan_s1 <= i_scan_clk;
            r_scan_s2 <= r_scan_s1;
            r_scan_d  <= r_scan_s2;
            r_col_s1  <= i_col;
            r_col_s2  <= r_col_s1;
            if (o_tick) begin
                if (!w_down) begin
                    r_cnt <= '0;
                end else if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Scores at most one hit per mole appearance and holds a hit flag for the VGA stage.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned HIT_HOLD_TICKS = 200
) (
    input logic        clk,
    input logic        rst,
    hit_judge_if.slave bus
);

    localparam int unsigned   HW        = $clog2(HIT_HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HIT_HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    state_t        r_state;
    logic [3:0]    r_pos;
    logic          r_hit_pulse, r_miss_pulse, r_escape_pulse, r_hit_level;
    logic [6:0]    r_hit_count;
    logic [HW-1:0] r_hold;
    logic          r_was_off;
    logic          w_tick, w_press, w_new_mole, w_idle;

    key_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .i_scan_clk(bus.scan_clk),
        .i_col     (bus.keypadCol),
        .o_tick    (w_tick),
        .o_press   (w_press)
    );

    assign w_new_mole = (bus.position != r_pos);
    assign w_idle     = !bus.inGame || bus.stop;

    assign bus.hit_pulse    = r_hit_pulse;
    assign bus.miss_pulse   = r_miss_pulse;
    assign bus.escape_pulse = r_escape_pulse;
    assign bus.hit_level    = r_hit_level;
    assign bus.hit_count    = r_hit_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pos          <= 4'd0;
            r_hit_pulse    <= 1'b0;
            r_miss_pulse   <= 1'b0;
            r_escape_pulse <= 1'b0;
            r_hit_level    <= 1'b0;
            r_hit_count    <= 7'd0;
            r_hold         <= '0;
            r_was_off      <= 1'b0;
        end else begin
            r_pos          <= bus.position;
            r_hit_pulse    <= 1'b0;
            r_miss_pulse   <= 1'b0;
            r_escape_pulse <= 1'b0;
            // Remembers that the game switch was off, so the score restarts on re-entry.
            if (!bus.inGame) r_was_off <= 1'b1;
            if (w_idle) begin
                r_state     <= IDLE;
                r_hit_level <= 1'b0;
                r_hold      <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= ARMED;
                        if (r_was_off) begin
                            r_hit_count <= 7'd0;
                            r_was_off   <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (w_new_mole) begin
                            r_escape_pulse <= 1'b1;
                        end else if (w_press) begin
                            if (bus.keypadBuf == bus.position) begin
                                r_hit_pulse <= 1'b1;
                                r_hit_count <= sat_inc(r_hit_count);
                                r_hold      <= HOLD_LOAD;
                                r_hit_level <= 1'b1;
                                r_state     <= HIT;
                            end else begin
                                r_miss_pulse <= 1'b1;
                            end
                        end
                    end
                    HIT: begin
                        if (w_new_mole) begin
                            r_hit_level <= 1'b0;
                            r_hold      <= '0;
                            r_state     <= ARMED;
                        end else if (w_tick) begin
                            if (r_hold <= HOLD_ONE) begin
                                r_hold      <= '0;
                                r_hit_level <= 1'b0;
                                r_state     <= DONE;
                            end else begin
                                r_hold <= r_hold - HOLD_ONE;
                            end
                        end
                    end
                    DONE: begin
                        if (w_new_mole) r_state <= ARMED;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hit_judge.md
# hit_judge

Whack-a-mole hit arbiter between the keypad scanner / random mole generator and the score and VGA stages. Samples the raw keypad column lines on the 1 kHz scan tick, debounces each press into a single press event, and compares it against the current mole position. Allows exactly one scored hit per mole appearance, and holds a display-level hit flag for the VGA stage. Replaces the combinational `keypadBuf == position` comparison, which double-counts held keys.

## Interface

Parameters:
- DEBOUNCE_TICKS, 20: consecutive scan ticks with a key down before a press is accepted.
- HIT_HOLD_TICKS, 200: scan ticks `hit_level` stays high after an accepted hit.

Ports (single clock domain; reset is asynchronous and active-high):
- clk, input, 1: 50 MHz system clock.
- rst, input, 1: asynchronous, active-high reset.
- scan_clk, input, 1: 1 kHz divider output, a level; it is not used as a clock.
- inGame, input, 1: game-enable switch.
- stop, input, 1: game-over from the timer.
- position, input, 4: current mole index (0–15).
- keypadCol, input, 4: raw keypad columns, active-low; 4'hF means no key.
- keypadBuf, input, 4: last decoded key index from the scanner.
- hit_pulse, output, 1: one-clk strobe per scored hit.
- miss_pulse, output, 1: one-clk strobe per accepted wrong-key press.
- escape_pulse, output, 1: one-clk strobe when a mole moves unhit.
- hit_level, output, 1: held hit indication for VGA.
- hit_count, output, 7: scored hits, saturating at 99.

## Operation

- scan_clk and keypadCol each pass through a 2-FF synchronizer.
- tick = rising edge of the synchronized scan_clk, 1 clk wide.
- Debounce:
  - down = synced keypadCol != 4'hF, sampled only on tick.
  - The counter increments on ticks with down=1, saturating at DEBOUNCE_TICKS.
  - The counter clears on any tick with down=0.
  - press = one-clk strobe on the tick where the counter reaches DEBOUNCE_TICKS.
  - A held key yields exactly one press. Release and re-press is required for the next press.
- Mole-change detect: pos_q registers position every clk. new_mole = (position != pos_q).
- FSM states:
  - IDLE: entered whenever inGame=0 or stop=1, from any state. Outputs are cleared except hit_count. When inGame=1 and stop=0, go to ARMED.
  - ARMED, press with keypadBuf == position: hit_pulse, hit_count+1 (saturating at 99), load hold counter, go to HIT.
  - ARMED, press with keypadBuf != position: miss_pulse, stay in ARMED.
  - ARMED, new_mole: escape_pulse, stay in ARMED (re-armed for the new mole).
  - HIT: hit_level=1. The hold counter decrements per tick. At 0, clear hit_level and go to DONE.
  - HIT or DONE, new_mole: clear hit_level, go to ARMED. No escape_pulse, since this mole was already scored.
  - DONE: presses are ignored; wait for new_mole.
- Priority within a cycle:
  1. IDLE condition.
  2. new_mole.
  3. press.
  - A press coinciding with new_mole is discarded.
- hit_count clears only on rst, or on the inGame 0→1 transition when leaving IDLE.

## Timing

- Reset values: FSM=IDLE, all pulses 0, hit_level 0, hit_count 0, debounce and hold counters 0, pos_q 0.
- Key latency: from keypadCol going low to the press strobe = 2 clk sync + DEBOUNCE_TICKS ticks + ≤1 tick phase.
- Scoring latency: hit_pulse, hit_count update and hit_level rise all occur in the clk after the press strobe.
- hit_level stays high for HIT_HOLD_TICKS ticks (±1 tick), or less if the mole moves first.
- Pulse width: every *_pulse is exactly 1 clk. At most one of hit/miss/escape is asserted per clk.
- Reset mid-hold: hit_level drops asynchronously. The next press after reset requires a fresh debounce.

## Structure

- Package hit_judge_pkg holds:
  - the state enum {IDLE, ARMED, HIT, DONE};
  - KEY_NONE = 4'hF;
  - HIT_COUNT_MAX = 99.
- Sub-module key_debounce contains the synchronizers, tick edge detect and debounce counter, and outputs tick and press.
- hit_judge contains the FSM, mole-change detect, hold counter and hit_count.

## Test plan

- Matching press: position=5, keypadBuf=5, hold col=4'hE for 25 ticks → exactly one hit_pulse, hit_count=1, hit_level high for 200 ticks, then state DONE.
- Held key, no repeat: keep the key held through a position change 5→9, keypadBuf=5 → no further hit or miss pulses. Release, then press key 9 → a hit is scored.
- Bounce rejection: a 10-tick press, release, then 15-tick press (DEBOUNCE_TICKS=20) → no press, no pulses, hit_count unchanged.
- Wrong key, then escape: position=3, press key 7 → miss_pulse. Then position→8 with no hit → escape_pulse. State stays ARMED.
- Simultaneous: press strobe in the same clk as a position change → no hit or miss pulse, state ARMED. Mid-HIT position change → hit_level low next clk, no escape_pulse.
- Saturation and reset: score 101 hits → hit_count=99. Assert stop mid-HIT → IDLE and hit_level=0 next clk. Assert rst asynchronously → all outputs 0 immediately.
